multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, register file, instruction register and unified memory port across several cycles per instruction.
- Drives the 2-bit ALUOp consumed by the ALU decoder:
  - 00 = add
  - 01 = sub
  - 10 = decode by funct3/funct7
  - 11 = pass immediate
- Sits between the instruction register opcode field and the datapath mux and enable controls.

Parameters:
- STATE_W, 4, width of the state encoding and of state_o. Must be at least 4.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  7  opcode field from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory handshake; present only with MEM_READY_EN
- alu_op  output  2  ALUOp to the ALU decoder
- alu_src_a  output  2  ALU A mux: 00 PC, 01 OldPC, 10 RD1
- alu_src_b  output  2  ALU B mux: 00 RD2, 01 ImmExt, 10 constant 4
- result_src  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
- adr_src  output  1  memory address mux: 0 PC, 1 Result
- ir_write  output  1  instruction register load enable
- reg_write  output  1  register file write enable
- mem_write  output  1  memory write enable
- pc_write  output  1  PC load enable, equal to pc_update OR (branch AND zero)
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- state_o  output  STATE_W  current state, for debug

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - The state register resets to FETCH (0).
- Outputs are Moore (decoded from state only), except pc_write, illegal_op and the MEM_READY_EN gating.
- While rst_n = 0, every output is forced to 0: ir_write, reg_write, mem_write, pc_write, illegal_op, instr_done, and all mux selects; state_o reads 0.
- Reset mid-instruction abandons the instruction; no write enable is asserted after rst_n falls.
- State encoding is fixed:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11
  - Codes 12–15 are unreachable and return to FETCH.
- Outputs per state; any signal not listed is 0, and alu_op defaults to 00:
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, alu_op=00, result_src=10, pc_update=1
  - DECODE: src_a=01, src_b=01, alu_op=00 (precomputes branch target)
  - MEMADR: src_a=10, src_b=01, alu_op=00
  - MEMREAD: result_src=00, adr_src=1
  - MEMWB: result_src=01, reg_write=1
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1
  - EXECR: src_a=10, src_b=00, alu_op=10
  - EXECI: src_a=10, src_b=01, alu_op=10
  - ALUWB: result_src=00, reg_write=1
  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1
  - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1
  - LUI: src_b=01, alu_op=11
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other opcode -> FETCH, with illegal_op=1 in that DECODE cycle
  - MEMADR: op=0000011 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR, EXECI, JAL, LUI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- instr_done is 1 in MEMWB, MEMWRITE, ALUWB and BEQ, and in the illegal-opcode DECODE cycle.
- Cycles per instruction, without stalls:
  - lw 5
  - sw 4
  - R-type, I-type, jal, lui 4
  - beq 3
  - illegal 2
- The op input is sampled only in DECODE and MEMADR. The instruction register holds op steady in those states.

Optional Feature:
- Macro: MULTICYCLE_CTRL_MEM_READY_EN.
- When defined:
  - The mem_ready port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state until mem_ready=1.
  - In FETCH, ir_write and pc_write are asserted only in the cycle where mem_ready=1, so the PC increments exactly once per fetch.
  - In MEMWRITE, mem_write stays high until the ready cycle, and instr_done pulses only in that cycle.
  - Stall cycles add to the cycle counts above.
- When undefined:
  - The port is absent and behaviour is identical to mem_ready tied to 1.

Test Plan:
- Reset: assert rst_n=0 in the middle of an EXECR cycle -> all outputs 0 immediately. Release -> state_o=0 and ir_write=1 on the next cycle.
- lw (op=0000011) -> state_o trace 0,1,2,3,4,0. reg_write=1 only in state 4, with result_src=01. instr_done pulses once.
- R-type (op=0110011) -> trace 0,1,6,8. alu_op=10 in state 6. sw (op=0100011) -> trace 0,1,2,5 with mem_write=1 only in state 5.
- beq with zero=1 -> pc_write=1 in BEQ. Same instruction with zero=0 -> pc_write=0 in BEQ. Both take 3 cycles.
- lui (op=0110111) -> alu_op=11 and src_b=01 in state 11, then ALUWB. Opcode 1111111 -> illegal_op=1 for one cycle in DECODE, then state returns to FETCH.
- With MULTICYCLE_CTRL_MEM_READY_EN, hold mem_ready=0 for 3 cycles in FETCH -> state stays 0, pc_write=0 and ir_write=0. The cycle mem_ready rises -> single pc_write pulse, then DECODE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for the multicycle RV32I core.
//
// Sequences the shared ALU, register file, instruction register and unified
// memory port over several cycles per instruction. Outputs are decoded from
// the current state (Moore), except pc_write (branch AND zero), illegal_op
// (decoded from op in DECODE) and the optional memory-ready gating.
//
// Optional feature: define MULTICYCLE_CTRL_MEM_READY_EN to add the mem_ready
// handshake. FETCH, MEMREAD and MEMWRITE then wait for mem_ready=1. Without
// the macro the port is absent and the block behaves as if mem_ready=1.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset; forces every output to 0
//   op[6:0]     in   opcode field from the instruction register
//   zero        in   ALU zero flag
//   mem_ready   in   memory handshake (only with MULTICYCLE_CTRL_MEM_READY_EN)
//   alu_op      out  00 add, 01 sub, 10 funct decode, 11 pass immediate
//   alu_src_a   out  00 PC, 01 OldPC, 10 RD1
//   alu_src_b   out  00 RD2, 01 ImmExt, 10 constant 4
//   result_src  out  00 ALUOut, 01 Data, 10 ALUResult
//   adr_src     out  0 PC, 1 Result
//   ir_write    out  instruction register load enable
//   reg_write   out  register file write enable
//   mem_write   out  memory write enable
//   pc_write    out  PC load enable = pc_update | (branch & zero)
//   illegal_op  out  one-cycle pulse on an unsupported opcode
//   instr_done  out  one-cycle pulse in the last cycle of each instruction
//   state_o     out  current state, for debug
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    input  logic               mem_ready,
`endif
    output logic [1:0]         alu_op,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic               adr_src,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               pc_write,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        EXECI    = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BEQ      = STATE_W'(9),
        JAL      = STATE_W'(10),
        LUI      = STATE_W'(11)
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;
    logic   pc_update;
    logic   branch;

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // IR load and PC increment only in the cycle the fetch
                // completes, so a stalled fetch bumps the PC exactly once.
                ir_write   = mem_rdy;
                pc_update  = mem_rdy;
                if (mem_rdy) state_d = DECODE;
            end
            DECODE: begin
                // OldPC + ImmExt: branch target is ready by the BEQ cycle.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECR;
                    OP_ITYPE:     state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_LUI:       state_d = LUI;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_rdy) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_rdy;
                if (mem_rdy) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            LUI: begin
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                state_d   = ALUWB;
            end
            default: begin
                // Unused encodings recover to FETCH with all controls idle.
                state_d = FETCH;
            end
        endcase

        pc_write = pc_update | (branch & zero);

        // The state register already reads FETCH during reset, but FETCH
        // decodes to active enables; mask everything so nothing writes
        // while rst_n is low.
        if (!rst_n) begin
            alu_op     = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            result_src = 2'b00;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            pc_write   = 1'b0;
            illegal_op = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       pc_write;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
`ifdef MULTICYCLE_CTRL_MEM_READY_EN
        .mem_ready  (mem_ready),
`endif
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .pc_write   (pc_write),
        .illegal_op (illegal_op),
        .instr_done (instr_done),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control vector:
    // {alu_op, src_a, src_b, result_src, adr_src, ir_write, reg_write,
    //  mem_write, pc_write, illegal_op, instr_done}
    function automatic logic [14:0] ev(input logic [1:0] aop, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic adr, input logic ir, input logic rw,
                                       input logic mw, input logic pcw, input logic ill,
                                       input logic dn);
        return {aop, sa, sb, rs, adr, ir, rw, mw, pcw, ill, dn};
    endfunction

    function automatic logic [14:0] obs();
        return {alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
                reg_write, mem_write, pc_write, illegal_op, instr_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic [3:0] st, input logic [14:0] e);
        @(posedge clk);
        #1;
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_ctl"}, 32'(obs()), 32'(e));
    endtask

    logic [14:0] V_FETCH, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, V_MEMWRITE;
    logic [14:0] V_EXECR, V_EXECI, V_ALUWB, V_BEQ_T, V_BEQ_N, V_JAL, V_LUI;
    logic [14:0] V_ILLEGAL, V_ZERO;

    initial begin
        V_FETCH    = ev(2'b00, 2'b00, 2'b10, 2'b10, 0, 1, 0, 0, 1, 0, 0);
        V_DECODE   = ev(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_MEMADR   = ev(2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_MEMREAD  = ev(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        V_MEMWB    = ev(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0, 1);
        V_MEMWRITE = ev(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 1);
        V_EXECR    = ev(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_EXECI    = ev(2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_ALUWB    = ev(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 1);
        V_BEQ_T    = ev(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        V_BEQ_N    = ev(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        V_JAL      = ev(2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        V_LUI      = ev(2'b11, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        V_ILLEGAL  = ev(2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        V_ZERO     = 15'd0;

        rst_n     = 1'b0;
        op        = 7'b0000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held: everything 0, including across a clock edge.
        #12;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ctl", 32'(obs()), 32'(V_ZERO));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_state", 32'(state_o), 32'd0);
        check("rel_ctl", 32'(obs()), 32'(V_FETCH));

        // lw: 0,1,2,3,4,0
        op = 7'b0000011;
        step("lw_dec", 4'd1, V_DECODE);
        step("lw_adr", 4'd2, V_MEMADR);
        step("lw_rd", 4'd3, V_MEMREAD);
        step("lw_wb", 4'd4, V_MEMWB);
        step("lw_fetch", 4'd0, V_FETCH);

        // R-type: 0,1,6,8,0
        op = 7'b0110011;
        step("r_dec", 4'd1, V_DECODE);
        step("r_exec", 4'd6, V_EXECR);
        step("r_wb", 4'd8, V_ALUWB);
        step("r_fetch", 4'd0, V_FETCH);

        // sw: 0,1,2,5,0
        op = 7'b0100011;
        step("sw_dec", 4'd1, V_DECODE);
        step("sw_adr", 4'd2, V_MEMADR);
        step("sw_wr", 4'd5, V_MEMWRITE);
        step("sw_fetch", 4'd0, V_FETCH);

        // beq taken then not taken, 3 cycles each
        op = 7'b1100011;
        zero = 1'b1;
        step("beqt_dec", 4'd1, V_DECODE);
        step("beqt_beq", 4'd9, V_BEQ_T);
        step("beqt_fetch", 4'd0, V_FETCH);
        zero = 1'b0;
        step("beqn_dec", 4'd1, V_DECODE);
        step("beqn_beq", 4'd9, V_BEQ_N);
        step("beqn_fetch", 4'd0, V_FETCH);

        // jal
        op = 7'b1101111;
        step("jal_dec", 4'd1, V_DECODE);
        step("jal_jal", 4'd10, V_JAL);
        step("jal_wb", 4'd8, V_ALUWB);
        step("jal_fetch", 4'd0, V_FETCH);

        // I-type
        op = 7'b0010011;
        step("i_dec", 4'd1, V_DECODE);
        step("i_exec", 4'd7, V_EXECI);
        step("i_wb", 4'd8, V_ALUWB);
        step("i_fetch", 4'd0, V_FETCH);

        // lui
        op = 7'b0110111;
        step("lui_dec", 4'd1, V_DECODE);
        step("lui_lui", 4'd11, V_LUI);
        step("lui_wb", 4'd8, V_ALUWB);
        step("lui_fetch", 4'd0, V_FETCH);

        // illegal opcode: 2 cycles, illegal_op pulse in DECODE only
        op = 7'b1111111;
        step("ill_dec", 4'd1, V_ILLEGAL);
        step("ill_fetch", 4'd0, V_FETCH);

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
        // Fetch stalled for 3 cycles, then a single completing cycle.
        op = 7'b0110011;
        mem_ready = 1'b0;
        #1;
        check("stall0_ctl", 32'(obs()), 32'(ev(2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < 3; i++) begin
            step("stall", 4'd0, ev(2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        end
        mem_ready = 1'b1;
        #1;
        check("stall_rdy_ctl", 32'(obs()), 32'(V_FETCH));
        step("stall_dec", 4'd1, V_DECODE);
        step("stall_exec", 4'd6, V_EXECR);
        step("stall_wb", 4'd8, V_ALUWB);
        step("stall_fetch", 4'd0, V_FETCH);
`endif

        // Reset in the middle of an EXECR cycle.
        op = 7'b0110011;
        step("mr_dec", 4'd1, V_DECODE);
        step("mr_exec", 4'd6, V_EXECR);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rst_state", 32'(state_o), 32'd0);
        check("mr_rst_ctl", 32'(obs()), 32'(V_ZERO));
        @(posedge clk);
        #1;
        check("mr_hold_state", 32'(state_o), 32'd0);
        check("mr_hold_ctl", 32'(obs()), 32'(V_ZERO));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_rel_state", 32'(state_o), 32'd0);
        check("mr_rel_ctl", 32'(obs()), 32'(V_FETCH));
        step("mr_dec2", 4'd1, V_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
